// File: rtl/voq_in_dispatch_pkg.sv
// Shared types and sizing helpers for the VOQ input dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package voq_in_dispatch_pkg;

  // Dispatcher control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Default build: 4 ports x 2 priorities, 32-bit beats, up to 16 beats per packet
  localparam int DEF_PORT_NUB   = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PRIO_NUB   = 2;
  localparam int DEF_LEN_MAX    = 16;

  // Index width that never collapses to zero bits for n <= 2
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a flat queue index q = dest*prios + prio
  function automatic int qidx_width(input int ports, input int prios);
    return clog2_min1(ports * prios);
  endfunction

endpackage

// File: rtl/voq_in_dispatch_len_counter.sv
// Per-packet beat counter with truncation flag at LEN_MAX beats.
// Latency: len/trunc are combinational for the beat being written; count updates on the next edge.
// Backpressure: none; only advances on beats the dispatcher actually writes.
module voq_len_counter #(
  parameter  int LEN_MAX = 16,
  localparam int LW      = $clog2(LEN_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          beat,
  input  logic          last,
  output logic [LW-1:0] len,
  output logic          trunc
);

  logic [LW-1:0] cnt_q;

  // Count includes the current beat; the counter idles at zero between packets
  always_comb begin
    len   = cnt_q + LW'(1);
    trunc = !last && (32'(len) >= LEN_MAX);
  end

  // Advance on every written beat, return to zero when the packet closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (beat) begin
      cnt_q <= (last || trunc) ? '0 : len;
    end
  end

endmodule

// File: rtl/voq_in_dispatch.sv
// Dispatches a packet beat stream into one-hot per-port/per-priority VOQ write strobes.
// Latency: an accepted beat appears on m_wr_en/m_data/m_eop exactly 1 cycle later; done pulses with m_eop.
// Backpressure: s_ready follows the registered full flag of the selected queue; full at SOP stalls or drops.
module voq_in_dispatch
  import voq_in_dispatch_pkg::*;
#(
  parameter  int PORT_NUB     = DEF_PORT_NUB,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int PRIO_NUB     = DEF_PRIO_NUB,
  parameter  int LEN_MAX      = DEF_LEN_MAX,
  parameter  bit DROP_ON_FULL = 1'b0,
  localparam int NQ           = PORT_NUB * PRIO_NUB,
  localparam int DW           = clog2_min1(PORT_NUB),
  localparam int PW           = clog2_min1(PRIO_NUB),
  localparam int QW           = qidx_width(PORT_NUB, PRIO_NUB),
  localparam int LW           = $clog2(LEN_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sop,
  input  logic                  s_eop,
  input  logic [DW-1:0]         s_dest,
  input  logic [PW-1:0]         s_prio,
  input  logic [NQ-1:0]         voq_full,
  output logic [NQ-1:0]         m_wr_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_eop,
  output logic [PORT_NUB-1:0]   done_out,
  output logic [LW-1:0]         done_len,
  output logic [15:0]           drop_cnt
);

  state_e        state_q;
  state_e        state_nxt;
  logic          run_q;
  logic [NQ-1:0] full_q;
  logic [QW-1:0] sel_q;
  logic [DW-1:0] dest_q;

  logic          dest_ok;
  logic [QW-1:0] sel_new;
  logic          full_new;
  logic          rdy;
  logic          wr;
  logic          start;
  logic          drop_inc;
  logic [QW-1:0] sel_wr;
  logic [DW-1:0] dest_wr;
  logic [LW-1:0] len;
  logic          trunc;
  logic          pkt_end;

  voq_len_counter #(
    .LEN_MAX (LEN_MAX)
  ) u_len (
    .clk   (clk),
    .rst_n (rst_n),
    .beat  (wr),
    .last  (s_eop),
    .len   (len),
    .trunc (trunc)
  );

  // A write closes the packet either on the real last beat or on the LEN_MAX cut
  assign pkt_end = wr && (s_eop || trunc);
  assign s_ready = rdy;

  // Accept/discard/forward decision for the beat currently offered
  always_comb begin
    dest_ok   = (32'(s_dest) < PORT_NUB) && (32'(s_prio) < PRIO_NUB);
    sel_new   = QW'(s_dest) * QW'(PRIO_NUB) + QW'(s_prio);
    full_new  = dest_ok && full_q[sel_new];
    rdy       = 1'b0;
    wr        = 1'b0;
    start     = 1'b0;
    drop_inc  = 1'b0;
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // Stall-mode only refuses an SOP whose target queue is full; everything else is taken
        rdy = run_q && !(s_valid && s_sop && full_new && !DROP_ON_FULL);
        if (s_valid && rdy) begin
          if (!s_sop) begin
            drop_inc = 1'b1;
          end else if (!dest_ok || full_new) begin
            drop_inc = 1'b1;
            if (!s_eop) state_nxt = ST_DROP;
          end else begin
            wr    = 1'b1;
            start = 1'b1;
            if (!s_eop) state_nxt = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        // Mid-packet SOP is plain payload; destination stays as latched
        rdy = !full_q[sel_q];
        if (s_valid && rdy) begin
          wr = 1'b1;
          if (s_eop) state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        rdy = 1'b1;
        if (s_valid && s_eop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    sel_wr  = start ? sel_new : sel_q;
    dest_wr = start ? s_dest : dest_q;
  end

  // State, registered full view, selection latch and the one-cycle output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      full_q   <= '0;
      sel_q    <= '0;
      dest_q   <= '0;
      m_wr_en  <= '0;
      m_data   <= '0;
      m_eop    <= 1'b0;
      done_out <= '0;
      done_len <= '0;
      drop_cnt <= '0;
    end else begin
      run_q  <= 1'b1;
      full_q <= voq_full;
      // A truncated packet keeps swallowing its tail until the real last beat
      if (wr && trunc) begin
        state_q <= ST_DROP;
      end else begin
        state_q <= state_nxt;
      end
      if (start) begin
        sel_q  <= sel_new;
        dest_q <= s_dest;
      end
      m_wr_en <= wr ? (NQ'(1) << sel_wr) : '0;
      if (wr) m_data <= s_data;
      m_eop    <= pkt_end;
      done_out <= pkt_end ? (PORT_NUB'(1) << dest_wr) : '0;
      done_len <= pkt_end ? len : '0;
      if ((drop_inc || (wr && trunc)) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/voq_in_dispatch.md
VOQ_IN_DISPATCH -- requirements
Module: voq_in_dispatch

Interface
REQ-001 SHALL have parameter PORT_NUB, default `PORT_NUB_TOTAL, number of destination ports (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, payload beat width.
REQ-003 SHALL have parameter PRIO_NUB, default `PRIORITY, priority classes per port (>=1).
REQ-004 SHALL have parameter LEN_MAX, default `DATA_LENGTH_MAX, maximum beats per packet.
REQ-005 SHALL have parameter DROP_ON_FULL, default 0; 1 = drop packets whose queue is full at SOP, 0 = stall.
REQ-006 One clock; reset is asynchronous and active-low: clk input 1, rst_n input 1.
REQ-007 s_valid input 1, upstream beat valid.
REQ-008 s_ready output 1, beat accepted when s_valid && s_ready.
REQ-009 s_data input DATA_WIDTH, payload.
REQ-010 s_sop / s_eop input 1 each, first / last beat of packet.
REQ-011 s_dest input clog2(PORT_NUB), destination port, sampled on SOP beat only.
REQ-012 s_prio input clog2(PRIO_NUB) (min 1), priority class, sampled on SOP beat only.
REQ-013 voq_full input PORT_NUB*PRIO_NUB, per-queue full, index q = dest*PRIO_NUB+prio.
REQ-014 m_wr_en output PORT_NUB*PRIO_NUB, one-hot queue write strobe.
REQ-015 m_data output DATA_WIDTH and m_eop output 1, write payload / last-beat flag.
REQ-016 done_out output PORT_NUB, one-cycle pulse on packet completion, bit = dest.
REQ-017 done_len output clog2(LEN_MAX+1), beat count of completed packet, valid with done_out.
REQ-018 drop_cnt output 16, saturating count of dropped/truncated/orphan packets.

Function
REQ-019 voq_full SHALL be registered once (full_q); all decisions use full_q; downstream queues SHALL assert full with >=2 free entries.
REQ-020 FSM states SHALL be IDLE, FWD, DROP.
REQ-021 IDLE: s_ready=1; accepted SOP beat latches dest/prio into sel; if full_q[sel_new]=1 and DROP_ON_FULL=1 -> DROP, else if full_q[sel_new]=1 and DROP_ON_FULL=0 -> s_ready SHALL be 0 that cycle (beat not accepted), else beat written, -> FWD (or stays IDLE if s_eop also 1).
REQ-022 IDLE: accepted beat without s_sop SHALL be discarded and drop_cnt incremented.
REQ-023 FWD: s_ready = !full_q[sel]; each accepted beat written; accepted s_eop -> IDLE.
REQ-024 FWD: s_sop on a non-first beat SHALL be treated as data (no re-sampling of dest).
REQ-025 DROP: s_ready=1, beats discarded, accepted s_eop -> IDLE, drop_cnt incremented once per packet.
REQ-026 Write latency SHALL be exactly 1 cycle: accepted beat at cycle N -> m_wr_en[sel], m_data, m_eop at N+1; m_wr_en=0 otherwise.
REQ-027 Beat counter SHALL count beats incl. SOP; if count reaches LEN_MAX without s_eop, that beat SHALL be written with m_eop=1, drop_cnt incremented, FSM -> DROP.
REQ-028 done_out[sel] and done_len SHALL pulse in the same cycle as the m_eop=1 write; done_len=0 otherwise.
REQ-029 Single-beat packet (s_sop && s_eop) SHALL write one beat with m_eop=1 and done_len=1.
REQ-030 drop_cnt SHALL saturate at 0xFFFF.
REQ-031 Out-of-range s_dest (>=PORT_NUB) at SOP SHALL be handled as DROP.

Reset
REQ-032 On rst_n=0: state=IDLE, full_q=0, counters=0, s_ready=0 while asserted, m_wr_en=0, m_data=0, m_eop=0, done_out=0, done_len=0, drop_cnt=0.
REQ-033 Reset mid-packet SHALL abandon the packet without emitting m_eop or done_out.

Structure
REQ-034 State encoding and queue-index width function SHALL live in shared package voq_pkg.vh alongside generate_parameter.vh.
REQ-035 Beat counter with LEN_MAX truncation SHALL be sub-module voq_len_counter; FSM and output register stay in top.

Verification
REQ-036 PORT_NUB=4, PRIO_NUB=2: 3-beat packet dest=2 prio=1 -> m_wr_en[5] high 3 cycles, m_eop on 3rd, done_out=4'b0100, done_len=3.
REQ-037 DROP_ON_FULL=0: voq_full[5] high mid-packet -> s_ready low from 1 cycle later, no beat lost, done_len unchanged.
REQ-038 DROP_ON_FULL=1: voq_full[0] high, SOP dest=0 prio=0, 4 beats -> no m_wr_en, drop_cnt=1.
REQ-039 LEN_MAX=8, 10-beat packet -> 8 writes, 8th with m_eop=1, done_len=8, drop_cnt=1, beats 9-10 discarded.
REQ-040 Back-to-back single-beat packets dest 0,1,3 -> done_out 0001,0010,1000 on consecutive cycles.
REQ-041 rst_n low during beat 2 of 5 -> all outputs 0; next SOP packet forwarded normally.
